md_hilo_ctrl: RTL and testbench
===============================

Name: md_hilo_ctrl

Overview:
Sequencer and owner of the HI/LO registers for the EX-stage multiply/divide resources. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX over a valid/ready handshake and drives start and operand signals into the shared iterative divider and pipelined multiplier. It counts multiplier latency, waits for the divider's complete, and writes the results into HI/LO. It also supplies EX with its stall condition and handles flush and divider-timeout aborts.

Parameters:
MUL_CYCLES, 2, cycles from the mul_start cycle until mul_res is valid (range 1..15)
DIV_TIMEOUT, 40, maximum number of DIV_WAIT cycles before the divide is aborted (range 2..255)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  EX holds a mul/div/mthi/mtlo op
req_ready  out  1  controller can accept a request
req_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; other codes are ignored (accepted, no effect)
req_src1  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
req_src2  in  32  rt operand
req_cancel  in  1  flush: kill the in-flight or offered op
mul_start  out  1  one-cycle start pulse to the multiplier
mul_signed  out  1  signed multiply, held
mul_x, mul_y  out  32  multiplier operands, held
mul_res  in  64  multiplier product
div_start  out  1  one-cycle start pulse to the divider
div_abort  out  1  one-cycle pulse that clears the divider's internal state
div_signed  out  1  signed divide, held
div_x, div_y  out  32  divider operands, held
div_complete  in  1  divider result valid
div_s, div_r  in  32  quotient, remainder
hi, lo  out  32  architectural HI/LO registers
busy  out  1  state != IDLE; EX stalls on it
done_pulse  out  1  one cycle after HI/LO are written by a mul/div/div-by-0 completion
md_err  out  1  sticky divider-timeout flag

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; hi, lo, all operand outputs and counters = 0.
  - mul_start, div_start, div_abort, done_pulse, md_err = 0.
  - Takes effect immediately, including mid-operation.
- States: IDLE, MUL_WAIT, DIV_WAIT.
- req_ready = (state==IDLE) && !req_cancel. Accept = req_valid && req_ready at a rising edge.
- Operands and signedness are latched at the accept edge and held until the op ends.
- MTHI / MTLO (IDLE):
  - hi (or lo) <= req_src1 at the accept edge.
  - State stays IDLE; no done_pulse.
- MULT/MULTU:
  - Accept edge e0 -> MUL_WAIT; mul_start=1 for cycle C1 only; counter loaded with MUL_CYCLES.
  - Counter decrements every MUL_WAIT cycle.
  - At edge e(1+MUL_CYCLES): {hi,lo} <= mul_res, state <- IDLE.
  - done_pulse=1 in the following cycle; req_ready is high in that same cycle.
- DIV/DIVU, req_src2 != 0:
  - Accept -> DIV_WAIT; div_start=1 for the first DIV_WAIT cycle only.
  - At the first edge where div_complete=1: lo<=div_s, hi<=div_r, state <- IDLE, done_pulse next cycle.
  - div_complete is ignored outside DIV_WAIT and in the div_start cycle.
- DIV/DIVU, req_src2 == 0:
  - No div_start; hi/lo unchanged; state stays IDLE.
  - done_pulse in the cycle after accept.
- Timeout:
  - Wait counter clears on DIV_WAIT entry and increments each DIV_WAIT cycle.
  - When it reaches DIV_TIMEOUT with div_complete=0: state <- IDLE, div_abort pulse next cycle, md_err <- 1, hi/lo unchanged.
  - md_err is cleared only by reset.
- Cancel:
  - In MUL_WAIT or DIV_WAIT: state <- IDLE at the next edge; hi/lo unchanged; no done_pulse.
  - A cancel in DIV_WAIT also produces a div_abort pulse next cycle.
  - Cancel has priority over a coincident div_complete or final multiply count (result discarded).
  - In IDLE: blocks acceptance that cycle.
- No back-to-back overlap: a new mul/div is accepted no earlier than the done_pulse cycle.
- busy=1 exactly while in MUL_WAIT/DIV_WAIT.

Test Plan:
- Signed multiply: MULT src1=0xFFFFFFFD, src2=5, mul model with latency 2 -> mul_start 1 cycle after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at edge e3; done_pulse in cycle C4; busy=1 for cycles C1-C3.
- Unsigned divide: DIVU 100/7, divider completes 33 cycles after start -> lo=14, hi=2; req_ready=0 and busy=1 throughout the wait; a MTHI offered meanwhile is held off, then accepted in the done_pulse cycle.
- Divide by zero: hi=0x11, lo=0x22, DIV src2=0 -> no div_start; hi/lo unchanged; done_pulse 1 cycle after accept; req_ready stays 1.
- Flush: DIV accepted, req_cancel=1 on wait cycle 10 -> IDLE next edge; div_abort one pulse; hi/lo unchanged; no done_pulse. A MULTU 0xFFFFFFFF*2 offered next cycle is accepted -> hi=1, lo=0xFFFFFFFE.
- Timeout: div_complete held 0 with DIV_TIMEOUT=40 -> abort after 40 DIV_WAIT cycles; md_err=1 and stays 1 across later ops; MTLO 0x5 then sets lo=5.
- Reset mid-operation: assert resetn=0 asynchronously in MUL_WAIT -> outputs zero immediately, without waiting for a clock edge; after release, an MTHI 0xA is accepted on the first edge.

Source files
------------

// File: rtl/md_hilo_ctrl.sv
// md_hilo_ctrl
//   Owns the architectural HI/LO registers and sequences the shared EX-stage
//   multiplier (fixed latency, pipelined) and iterative divider.
//   EX offers one op at a time over req_valid/req_ready:
//     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
//   Other opcodes are accepted and have no effect.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE, no cancel)
//   req_op, req_src1, req_src2  opcode and rs/rt operands
//   req_cancel                  flush of the offered or in-flight op
//   mul_start, mul_signed,      multiplier start pulse, held signedness,
//   mul_x, mul_y, mul_res       held operands and 64-bit product
//   div_start, div_abort,       divider start / abort pulses,
//   div_signed, div_x, div_y    held signedness and operands
//   div_complete, div_s, div_r  divider result valid, quotient, remainder
//   hi, lo                      architectural HI/LO
//   busy                        a mul/div is in flight (EX stalls)
//   done_pulse                  one cycle after HI/LO written by a mul/div
//   md_err                      sticky divider timeout flag
module md_hilo_ctrl #(
   parameter int MUL_CYCLES  = 2,
   parameter int DIV_TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        req_cancel,
   output logic        mul_start,
   output logic        mul_signed,
   output logic [31:0] mul_x,
   output logic [31:0] mul_y,
   input  logic [63:0] mul_res,
   output logic        div_start,
   output logic        div_abort,
   output logic        div_signed,
   output logic [31:0] div_x,
   output logic [31:0] div_y,
   input  logic        div_complete,
   input  logic [31:0] div_s,
   input  logic [31:0] div_r,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done_pulse,
   output logic        md_err
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES);
   // Last DIV_WAIT cycle index: the wait counter is 0 in the first cycle.
   localparam logic [7:0] DIV_LAST     = 8'(DIV_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

   state_t      state, state_next;
   logic [3:0]  mul_cnt;
   logic [7:0]  div_cnt;

   logic accept, op_is_mul, op_is_div, src2_zero;
   logic go_mul, go_div, div_zero, wr_mul, wr_div;
   logic wr_hi_mt, wr_lo_mt, abort_next, err_set;

   assign req_ready = (state == IDLE) && !req_cancel;
   assign busy      = (state != IDLE);
   assign accept    = req_valid && req_ready;
   assign op_is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
   assign op_is_div = (req_op == OP_DIV)  || (req_op == OP_DIVU);
   assign src2_zero = (req_src2 == 32'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      go_mul     = 1'b0;
      go_div     = 1'b0;
      div_zero   = 1'b0;
      wr_mul     = 1'b0;
      wr_div     = 1'b0;
      wr_hi_mt   = 1'b0;
      wr_lo_mt   = 1'b0;
      abort_next = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (op_is_mul) begin
                  go_mul     = 1'b1;
                  state_next = MUL_WAIT;
               end else if (op_is_div && !src2_zero) begin
                  go_div     = 1'b1;
                  state_next = DIV_WAIT;
               end else if (op_is_div) begin
                  // Divide by zero leaves HI/LO alone but still completes.
                  div_zero = 1'b1;
               end else begin
                  wr_hi_mt = (req_op == OP_MTHI);
                  wr_lo_mt = (req_op == OP_MTLO);
               end
            end
         end
         MUL_WAIT: begin
            // Cancel wins over the final count: the product is dropped.
            if (req_cancel) begin
               state_next = IDLE;
            end else if (mul_cnt == 4'd0) begin
               wr_mul     = 1'b1;
               state_next = IDLE;
            end
         end
         DIV_WAIT: begin
            if (req_cancel) begin
               abort_next = 1'b1;
               state_next = IDLE;
            end else if (div_complete && !div_start) begin
               // div_complete during the start cycle is a stale result.
               wr_div     = 1'b1;
               state_next = IDLE;
            end else if (div_cnt == DIV_LAST) begin
               abort_next = 1'b1;
               err_set    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mul_start  <= 1'b0;
         mul_signed <= 1'b0;
         mul_x      <= 32'd0;
         mul_y      <= 32'd0;
         div_start  <= 1'b0;
         div_abort  <= 1'b0;
         div_signed <= 1'b0;
         div_x      <= 32'd0;
         div_y      <= 32'd0;
         hi         <= 32'd0;
         lo         <= 32'd0;
         done_pulse <= 1'b0;
         md_err     <= 1'b0;
         mul_cnt    <= 4'd0;
         div_cnt    <= 8'd0;
      end else begin
         mul_start  <= go_mul;
         div_start  <= go_div;
         div_abort  <= abort_next;
         done_pulse <= wr_mul || wr_div || div_zero;
         if (err_set) md_err <= 1'b1;

         if (go_mul) begin
            mul_x      <= req_src1;
            mul_y      <= req_src2;
            mul_signed <= (req_op == OP_MULT);
            mul_cnt    <= MUL_CNT_INIT;
         end else if (state == MUL_WAIT && mul_cnt != 4'd0) begin
            mul_cnt <= mul_cnt - 4'd1;
         end

         if (accept && op_is_div) begin
            div_x      <= req_src1;
            div_y      <= req_src2;
            div_signed <= (req_op == OP_DIV);
         end

         if (go_div)                div_cnt <= 8'd0;
         else if (state == DIV_WAIT) div_cnt <= div_cnt + 8'd1;

         if (wr_mul) begin
            {hi, lo} <= mul_res;
         end else if (wr_div) begin
            lo <= div_s;
            hi <= div_r;
         end else begin
            if (wr_hi_mt) hi <= req_src1;
            if (wr_lo_mt) lo <= req_src1;
         end
      end
   end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Bench for md_hilo_ctrl: a transaction-level model (op kind + age since
// accept) predicts every output each cycle; directed scenarios add literal
// expectations. Also stands in for the multiplier and divider.
module tb_md_hilo_ctrl;
   localparam int MUL_CYCLES  = 2;
   localparam int DIV_TIMEOUT = 40;

   logic        clk, resetn;
   logic        req_valid, req_cancel;
   logic [2:0]  req_op;
   logic [31:0] req_src1, req_src2;
   logic        req_ready;
   logic        mul_start, mul_signed, div_start, div_abort, div_signed;
   logic [31:0] mul_x, mul_y, div_x, div_y, div_s, div_r, hi, lo;
   logic [63:0] mul_res;
   logic        div_complete, busy, done_pulse, md_err;

   md_hilo_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2), .req_cancel(req_cancel),
      .mul_start(mul_start), .mul_signed(mul_signed), .mul_x(mul_x),
      .mul_y(mul_y), .mul_res(mul_res),
      .div_start(div_start), .div_abort(div_abort), .div_signed(div_signed),
      .div_x(div_x), .div_y(div_y), .div_complete(div_complete),
      .div_s(div_s), .div_r(div_r),
      .hi(hi), .lo(lo), .busy(busy), .done_pulse(done_pulse), .md_err(md_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic sgn);
      longint sx, sy;
      if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      return {32'd0, x} * {32'd0, y};
   endfunction

   // returns {quotient, remainder}
   function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic sgn);
      if (y == 32'd0) return 64'd0;
      if (sgn) return {32'($signed(x) / $signed(y)), 32'($signed(x) % $signed(y))};
      return {x / y, x % y};
   endfunction

   // ---------------- reference model ----------------
   // m_kind: 0 nothing in flight, 1 multiply, 2 divide; m_age = 1 in the
   // first cycle after the accept edge.
   int          m_kind, m_age;
   logic [31:0] m_hi, m_lo, m_mx, m_my, m_dx, m_dy;
   logic        m_msgn, m_dsgn, m_err, m_done, m_abort;
   logic [63:0] m_q;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_kind <= 0; m_age <= 0; m_hi <= '0; m_lo <= '0;
         m_mx <= '0; m_my <= '0; m_dx <= '0; m_dy <= '0;
         m_msgn <= 0; m_dsgn <= 0; m_err <= 0; m_done <= 0; m_abort <= 0;
      end else begin
         m_done  <= 0;
         m_abort <= 0;
         if (m_kind == 0) begin
            if (req_valid && !req_cancel) begin
               case (req_op)
                  3'd0, 3'd1: begin
                     m_kind <= 1; m_age <= 1;
                     m_mx <= req_src1; m_my <= req_src2; m_msgn <= (req_op == 3'd0);
                  end
                  3'd2, 3'd3: begin
                     m_dx <= req_src1; m_dy <= req_src2; m_dsgn <= (req_op == 3'd2);
                     if (req_src2 == 0) m_done <= 1;
                     else begin m_kind <= 2; m_age <= 1; end
                  end
                  3'd4: m_hi <= req_src1;
                  3'd5: m_lo <= req_src1;
                  default: ;
               endcase
            end
         end else if (req_cancel) begin
            m_kind <= 0;
            if (m_kind == 2) m_abort <= 1;
         end else if (m_kind == 1) begin
            if (m_age == 1 + MUL_CYCLES) begin
               {m_hi, m_lo} <= ref_mul(m_mx, m_my, m_msgn);
               m_done <= 1; m_kind <= 0;
            end else m_age <= m_age + 1;
         end else begin
            if (div_complete && m_age > 1) begin
               m_q = ref_div(m_dx, m_dy, m_dsgn);
               m_lo <= m_q[63:32]; m_hi <= m_q[31:0];
               m_done <= 1; m_kind <= 0;
            end else if (m_age == DIV_TIMEOUT) begin
               m_abort <= 1; m_err <= 1; m_kind <= 0;
            end else m_age <= m_age + 1;
         end
      end
   end

   // ---------------- multiplier / divider stand-ins ----------------
   int div_done_age;   // divide age at which div_complete fires (0: never)
   bit stale_c1;       // assert a stale div_complete in the div_start cycle

   always_comb begin
      mul_res = 64'hDEAD_BEEF_DEAD_BEEF;
      if (m_kind == 1 && m_age == 1 + MUL_CYCLES) mul_res = ref_mul(m_mx, m_my, m_msgn);
   end

   always_comb begin
      div_complete = 1'b0;
      if (m_kind == 2 && m_age == div_done_age) div_complete = 1'b1;
      if (m_kind == 2 && m_age == 1 && stale_c1) div_complete = 1'b1;
   end

   assign {div_s, div_r} = ref_div(m_dx, m_dy, m_dsgn);

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy",       64'(busy),       64'(m_kind != 0));
         chk("req_ready",  64'(req_ready),  64'(m_kind == 0 && !req_cancel));
         chk("mul_start",  64'(mul_start),  64'(m_kind == 1 && m_age == 1));
         chk("div_start",  64'(div_start),  64'(m_kind == 2 && m_age == 1));
         chk("div_abort",  64'(div_abort),  64'(m_abort));
         chk("done_pulse", 64'(done_pulse), 64'(m_done));
         chk("hi",         64'(hi),         64'(m_hi));
         chk("lo",         64'(lo),         64'(m_lo));
         chk("md_err",     64'(md_err),     64'(m_err));
         chk("mul_x",      64'(mul_x),      64'(m_mx));
         chk("mul_y",      64'(mul_y),      64'(m_my));
         chk("mul_signed", 64'(mul_signed), 64'(m_msgn));
         chk("div_x",      64'(div_x),      64'(m_dx));
         chk("div_y",      64'(div_y),      64'(m_dy));
         chk("div_signed", 64'(div_signed), 64'(m_dsgn));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
   endtask

   task automatic quiet();
      req_valid = 1'b0; req_cancel = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; quiet(); req_op = 3'd0; req_src1 = '0; req_src2 = '0;
      div_done_age = 0; stale_c1 = 0;
      cyc();
      cmp_en = 1;
      chk("lit_reset_busy", 64'(busy), 64'd0);
      chk("lit_reset_hi", 64'(hi), 64'd0);
      chk("lit_reset_ready", 64'(req_ready), 64'd1);
      #2 resetn = 1'b1;
      cyc();

      // MULT -3 * 5, latency 2
      offer(3'd0, 32'hFFFF_FFFD, 32'd5); cyc(); quiet();
      $display("txn MULT 0xfffffffd*5 accepted");
      chk("lit_mult_start_c1", 64'(mul_start), 64'd1);
      chk("lit_mult_busy_c1", 64'(busy), 64'd1);
      cyc(); chk("lit_mult_start_c2", 64'(mul_start), 64'd0);
      cyc(); chk("lit_mult_busy_c3", 64'(busy), 64'd1);
      cyc();
      chk("lit_mult_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("lit_mult_lo", 64'(lo), 64'hFFFF_FFF1);
      chk("lit_mult_done_c4", 64'(done_pulse), 64'd1);
      chk("lit_mult_ready_c4", 64'(req_ready), 64'd1);
      cyc(); chk("lit_mult_done_c5", 64'(done_pulse), 64'd0);

      // DIVU 100/7 completing 33 cycles after start; stale complete in C1;
      // MTHI held off meanwhile
      div_done_age = 34; stale_c1 = 1;
      offer(3'd3, 32'd100, 32'd7); cyc();
      $display("txn DIVU 100/7 accepted");
      chk("lit_divu_start", 64'(div_start), 64'd1);
      offer(3'd4, 32'h77, 32'd0);
      #1 chk("lit_divu_ready_c1", 64'(req_ready), 64'd0);
      for (int i = 2; i <= 34; i++) begin
         cyc();
         chk("lit_divu_wait_ready", 64'(req_ready), 64'd0);
      end
      cyc();
      chk("lit_divu_lo", 64'(lo), 64'd14);
      chk("lit_divu_hi", 64'(hi), 64'd2);
      chk("lit_divu_done", 64'(done_pulse), 64'd1);
      chk("lit_divu_ready_done", 64'(req_ready), 64'd1);
      cyc(); quiet();
      chk("lit_mthi_after_div", 64'(hi), 64'h77);
      $display("txn MTHI 0x77 accepted in done cycle");
      stale_c1 = 0; div_done_age = 0;

      // divide by zero
      offer(3'd4, 32'h11, 32'd0); cyc();
      offer(3'd5, 32'h22, 32'd0); cyc();
      offer(3'd2, 32'd5, 32'd0); cyc(); quiet();
      $display("txn DIV 5/0 accepted");
      chk("lit_div0_done", 64'(done_pulse), 64'd1);
      chk("lit_div0_nostart", 64'(div_start), 64'd0);
      chk("lit_div0_hilo", 64'({hi, lo}), 64'h0000_0011_0000_0022);
      chk("lit_div0_ready", 64'(req_ready), 64'd1);
      cyc();

      // undefined opcode: accepted, no effect
      offer(3'd6, 32'h5555, 32'h6666); cyc(); quiet();
      $display("txn op 6 accepted");
      chk("lit_op6_hilo", 64'({hi, lo}), 64'h0000_0011_0000_0022);

      // flush a DIV on wait cycle 10, then MULTU
      offer(3'd2, 32'hFFFF_FFCE, 32'd3); cyc(); quiet();
      $display("txn DIV -50/3 accepted");
      repeat (9) cyc();
      req_cancel = 1'b1; cyc(); req_cancel = 1'b0;
      $display("txn DIV flushed");
      chk("lit_flush_busy", 64'(busy), 64'd0);
      chk("lit_flush_abort", 64'(div_abort), 64'd1);
      chk("lit_flush_done", 64'(done_pulse), 64'd0);
      offer(3'd1, 32'hFFFF_FFFF, 32'd2); cyc(); quiet();
      chk("lit_flush_abort_once", 64'(div_abort), 64'd0);
      chk("lit_multu_start", 64'(mul_start), 64'd1);
      repeat (3) cyc();
      $display("txn MULTU 0xffffffff*2 done");
      chk("lit_multu_hilo", 64'({hi, lo}), 64'h0000_0001_FFFF_FFFE);
      cyc();

      // cancel on the final multiply cycle discards the product
      offer(3'd0, 32'd7, 32'd7); cyc(); quiet();
      cyc(); cyc();
      req_cancel = 1'b1; cyc(); req_cancel = 1'b0;
      $display("txn MULT 7*7 cancelled at last count");
      chk("lit_mcancel_hilo", 64'({hi, lo}), 64'h0000_0001_FFFF_FFFE);
      chk("lit_mcancel_done", 64'(done_pulse), 64'd0);

      // cancel in IDLE blocks acceptance
      req_cancel = 1'b1; offer(3'd5, 32'h99, 32'd0);
      #1 chk("lit_idle_cancel_ready", 64'(req_ready), 64'd0);
      cyc(); quiet();
      chk("lit_idle_cancel_lo", 64'(lo), 64'hFFFF_FFFE);

      // divider timeout
      offer(3'd2, 32'd9, 32'd2); cyc(); quiet();
      $display("txn DIV 9/2 accepted, divider silent");
      repeat (39) cyc();
      chk("lit_to_busy_c40", 64'(busy), 64'd1);
      cyc();
      chk("lit_to_busy_c41", 64'(busy), 64'd0);
      chk("lit_to_abort", 64'(div_abort), 64'd1);
      chk("lit_to_err", 64'(md_err), 64'd1);
      chk("lit_to_hilo", 64'({hi, lo}), 64'h0000_0001_FFFF_FFFE);
      offer(3'd1, 32'd3, 32'd4); cyc(); quiet(); repeat (3) cyc();
      chk("lit_after_to_mul", 64'({hi, lo}), 64'd12);
      offer(3'd5, 32'd5, 32'd0); cyc(); quiet();
      $display("txn MTLO 5 accepted");
      chk("lit_mtlo_lo", 64'(lo), 64'd5);
      chk("lit_err_sticky", 64'(md_err), 64'd1);

      // asynchronous reset in MUL_WAIT
      offer(3'd0, 32'd2, 32'd3); cyc(); quiet();
      #2 resetn = 1'b0;
      #1;
      $display("txn async reset in MUL_WAIT");
      chk("lit_areset_start", 64'(mul_start), 64'd0);
      chk("lit_areset_busy", 64'(busy), 64'd0);
      chk("lit_areset_lo", 64'(lo), 64'd0);
      chk("lit_areset_err", 64'(md_err), 64'd0);
      chk("lit_areset_mulx", 64'(mul_x), 64'd0);
      offer(3'd4, 32'hA, 32'd0);
      #2 resetn = 1'b1;
      cyc(); quiet();
      $display("txn MTHI 0xA after reset");
      chk("lit_post_reset_hi", 64'(hi), 64'hA);
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
